// File: rtl/layered_graphics_engine_pkg.sv
// -----------------------------------------------------------------------------
// layered_graphics_engine_pkg
// Shared definitions for the layered graphics engine:
//   - background mode encodings
//   - bar palette (8 entries) and layer palette (4 entries)
//   - per-layer reset positions
//   - one-axis sprite step with edge clamp / direction flip
// Palette entries are full-intensity on/off flags per channel ({r, g, b}).
// Any channel width can therefore be produced by replicating the flag.
// -----------------------------------------------------------------------------
package layered_graphics_engine_pkg;

  typedef enum logic [1:0] {
    MODE_BLACK    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  typedef logic [2:0] rgb_flag_t;

  typedef struct packed {
    logic       dir;
    logic [9:0] pos;
  } axis_t;

  localparam int MAX_LAYERS = 4;

  function automatic rgb_flag_t bar_colour(input logic [2:0] idx);
    rgb_flag_t c;
    case (idx)
      3'd0:    c = 3'b111; // white
      3'd1:    c = 3'b110; // yellow
      3'd2:    c = 3'b011; // cyan
      3'd3:    c = 3'b010; // green
      3'd4:    c = 3'b101; // magenta
      3'd5:    c = 3'b100; // red
      3'd6:    c = 3'b001; // blue
      default: c = 3'b000; // black
    endcase
    return c;
  endfunction

  function automatic rgb_flag_t layer_colour(input logic [1:0] idx);
    rgb_flag_t c;
    case (idx)
      2'd0:    c = 3'b100; // red
      2'd1:    c = 3'b010; // green
      2'd2:    c = 3'b001; // blue
      default: c = 3'b110; // yellow
    endcase
    return c;
  endfunction

  function automatic int layer_rst_x(input int idx);
    return idx * 64;
  endfunction

  function automatic int layer_rst_y(input int idx);
    return idx * 48;
  endfunction

  // One frame step along one axis. All arithmetic is 11 bits wide so that
  // pos + speed + size never wraps near the far edge.
  function automatic axis_t step_axis(input logic [9:0]  pos,
                                      input logic        dir,
                                      input logic [10:0] speed,
                                      input logic [10:0] size,
                                      input logic [10:0] active);
    logic [10:0] pos_w;
    axis_t       res;
    pos_w   = {1'b0, pos};
    res.dir = dir;
    res.pos = pos;
    if (dir) begin
      if (pos_w + speed + size > active) begin
        res.pos = 10'(active - size);
        res.dir = 1'b0;
      end else begin
        res.pos = 10'(pos_w + speed);
      end
    end else begin
      if (pos_w < speed) begin
        res.pos = '0;
        res.dir = 1'b1;
      end else begin
        res.pos = 10'(pos_w - speed);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/layered_graphics_engine_sprite_mover.sv
// -----------------------------------------------------------------------------
// sprite_mover
// Position/direction state of one sprite layer. On every end-of-frame pulse
// an enabled layer moves SPEED pixels per axis, clamping and reversing at
// the visible-area edges. The hit output is a combinational coverage test of
// the current pixel against the sprite square.
// Ports:
//   i_clk, i_rst     pixel clock, async active-high reset
//   i_eof            one-cycle end-of-frame pulse
//   i_en             latched layer enable for the current frame
//   i_x, i_y         current pixel coordinate
//   o_hit            pixel is covered by this (enabled) layer
// -----------------------------------------------------------------------------
module sprite_mover
  import layered_graphics_engine_pkg::*;
#(
  parameter int SPRITE_SIZE = 32,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SPEED       = 1,
  parameter int RST_X       = 0,
  parameter int RST_Y       = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_eof,
  input  logic       i_en,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output logic       o_hit
);

  logic [9:0] r_pos_x;
  logic [9:0] r_pos_y;
  logic       r_dir_x;
  logic       r_dir_y;

  axis_t       w_next_x;
  axis_t       w_next_y;
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [10:0] w_px;
  logic [10:0] w_py;

  assign w_next_x = step_axis(r_pos_x, r_dir_x, 11'(SPEED), 11'(SPRITE_SIZE), 11'(H_ACTIVE));
  assign w_next_y = step_axis(r_pos_y, r_dir_y, 11'(SPEED), 11'(SPRITE_SIZE), 11'(V_ACTIVE));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pos_x <= 10'(RST_X);
      r_pos_y <= 10'(RST_Y);
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (i_eof && i_en) begin
      r_pos_x <= w_next_x.pos;
      r_dir_x <= w_next_x.dir;
      r_pos_y <= w_next_y.pos;
      r_dir_y <= w_next_y.dir;
    end
  end

  assign w_x  = {1'b0, i_x};
  assign w_y  = {1'b0, i_y};
  assign w_px = {1'b0, r_pos_x};
  assign w_py = {1'b0, r_pos_y};

  assign o_hit = i_en
               && (w_x >= w_px) && (w_x < w_px + 11'(SPRITE_SIZE))
               && (w_y >= w_py) && (w_y < w_py + 11'(SPRITE_SIZE));

endmodule

// File: rtl/layered_graphics_engine.sv
// -----------------------------------------------------------------------------
// layered_graphics_engine
// Composites up to four moving sprite layers over a selectable background.
// Two-stage pipeline: stage 1 registers the composited colour of the current
// pixel, stage 2 is the output register, giving 2 clocks from x/y to r/g/b.
// Mode and layer enables are latched only at end-of-frame so a frame is
// always rendered with one consistent configuration.
// Ports:
//   i_clk, i_rst          pixel clock, async active-high reset
//   i_x, i_y              pixel coordinate from the timing generator
//   i_frame_active        (x,y) lies in the visible area
//   i_mode                background select (latched at EOF)
//   i_layer_en            per-layer enable (latched at EOF)
//   o_r, o_g, o_b         composited colour, zero when not valid
//   o_pixel_valid         frame_active aligned with colour
//   o_frame_cnt           completed-frame counter
// -----------------------------------------------------------------------------
module layered_graphics_engine
  import layered_graphics_engine_pkg::*;
#(
  parameter int NUM_LAYERS  = 2,
  parameter int CW          = 2,
  parameter int SPRITE_SIZE = 32,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [9:0]            i_x,
  input  logic [9:0]            i_y,
  input  logic                  i_frame_active,
  input  logic [1:0]            i_mode,
  input  logic [NUM_LAYERS-1:0] i_layer_en,
  output logic [CW-1:0]         o_r,
  output logic [CW-1:0]         o_g,
  output logic [CW-1:0]         o_b,
  output logic                  o_pixel_valid,
  output logic [7:0]            o_frame_cnt
);

  logic                  r_s1_valid;
  logic [CW-1:0]         r_s1_r;
  logic [CW-1:0]         r_s1_g;
  logic [CW-1:0]         r_s1_b;
  logic                  r_valid;
  logic [CW-1:0]         r_r;
  logic [CW-1:0]         r_g;
  logic [CW-1:0]         r_b;
  logic [7:0]            r_frame_cnt;
  mode_e                 r_mode;
  logic [NUM_LAYERS-1:0] r_layer_en;

  logic                  w_eof;
  logic [NUM_LAYERS-1:0] w_hit;
  rgb_flag_t             w_bar_flags;
  rgb_flag_t             w_layer_flags;
  logic                  w_layer_hit;
  logic [CW-1:0]         w_bg_r;
  logic [CW-1:0]         w_bg_g;
  logic [CW-1:0]         w_bg_b;
  logic [CW-1:0]         w_pix_r;
  logic [CW-1:0]         w_pix_g;
  logic [CW-1:0]         w_pix_b;

  assign w_eof = i_frame_active
              && (i_x == 10'(H_ACTIVE - 1))
              && (i_y == 10'(V_ACTIVE - 1));

  // Frame configuration; the enables in effect during the ending frame
  // decide which layers step at that same EOF.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_cnt <= '0;
      r_mode      <= MODE_BLACK;
      r_layer_en  <= '1;
    end else if (w_eof) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
      r_mode      <= mode_e'(i_mode);
      r_layer_en  <= i_layer_en;
    end
  end

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    sprite_mover #(
      .SPRITE_SIZE (SPRITE_SIZE),
      .H_ACTIVE    (H_ACTIVE),
      .V_ACTIVE    (V_ACTIVE),
      .SPEED       (g + 1),
      .RST_X       (layer_rst_x(g)),
      .RST_Y       (layer_rst_y(g))
    ) u_sprite_mover (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_eof (w_eof),
      .i_en  (r_layer_en[g]),
      .i_x   (i_x),
      .i_y   (i_y),
      .o_hit (w_hit[g])
    );
  end

  assign w_bar_flags = bar_colour(i_x[9:7]);

  always_comb begin
    w_bg_r = '0;
    w_bg_g = '0;
    w_bg_b = '0;
    case (r_mode)
      MODE_BARS: begin
        w_bg_r = {CW{w_bar_flags[2]}};
        w_bg_g = {CW{w_bar_flags[1]}};
        w_bg_b = {CW{w_bar_flags[0]}};
      end
      MODE_CHECKER: begin
        if (i_x[5] ^ i_y[5]) begin
          w_bg_r = '1;
          w_bg_g = '1;
          w_bg_b = '1;
        end
      end
      MODE_GRADIENT: begin
        w_bg_r = i_x[8 -: CW];
        w_bg_g = i_y[8 -: CW];
        w_bg_b = r_frame_cnt[7 -: CW];
      end
      default: ;
    endcase
  end

  // Scan from the highest index down so the lowest covering layer is the
  // last assignment and wins.
  always_comb begin
    w_layer_hit   = 1'b0;
    w_layer_flags = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_layer_hit   = 1'b1;
        w_layer_flags = layer_colour(2'(i));
      end
    end
  end

  always_comb begin
    w_pix_r = w_bg_r;
    w_pix_g = w_bg_g;
    w_pix_b = w_bg_b;
    if (w_layer_hit) begin
      w_pix_r = {CW{w_layer_flags[2]}};
      w_pix_g = {CW{w_layer_flags[1]}};
      w_pix_b = {CW{w_layer_flags[0]}};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_r     <= '0;
      r_s1_g     <= '0;
      r_s1_b     <= '0;
      r_valid    <= 1'b0;
      r_r        <= '0;
      r_g        <= '0;
      r_b        <= '0;
    end else begin
      r_s1_valid <= i_frame_active;
      r_s1_r     <= i_frame_active ? w_pix_r : '0;
      r_s1_g     <= i_frame_active ? w_pix_g : '0;
      r_s1_b     <= i_frame_active ? w_pix_b : '0;
      r_valid    <= r_s1_valid;
      r_r        <= r_s1_r;
      r_g        <= r_s1_g;
      r_b        <= r_s1_b;
    end
  end

  assign o_r           = r_r;
  assign o_g           = r_g;
  assign o_b           = r_b;
  assign o_pixel_valid = r_valid;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_layered_graphics_engine.sv
// -----------------------------------------------------------------------------
// tb_layered_graphics_engine
// Directed bench for layered_graphics_engine with default parameters.
// Colours are packed {r,g,b}, 2 bits per channel.
// -----------------------------------------------------------------------------
module tb_layered_graphics_engine;

  localparam logic [5:0] C_BLACK   = 6'b00_00_00;
  localparam logic [5:0] C_WHITE   = 6'b11_11_11;
  localparam logic [5:0] C_RED     = 6'b11_00_00;
  localparam logic [5:0] C_GREEN   = 6'b00_11_00;
  localparam logic [5:0] C_YELLOW  = 6'b11_11_00;
  localparam logic [5:0] C_MAGENTA = 6'b11_00_11;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_active;
  logic [1:0] mode;
  logic [1:0] layer_en;
  logic [1:0] r;
  logic [1:0] g;
  logic [1:0] b;
  logic       pixel_valid;
  logic [7:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  layered_graphics_engine dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_x            (x),
    .i_y            (y),
    .i_frame_active (frame_active),
    .i_mode         (mode),
    .i_layer_en     (layer_en),
    .o_r            (r),
    .o_g            (g),
    .o_b            (b),
    .o_pixel_valid  (pixel_valid),
    .o_frame_cnt    (frame_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    frame_active = 1'b0;
    x = '0;
    y = '0;
  endtask

  // Drive one pixel after an idle cycle; check the output is still idle one
  // clock later and carries the pixel two clocks later.
  task automatic probe(input string tag, input int px, input int py, input logic [5:0] exp);
    @(negedge clk);
    idle();
    @(negedge clk);
    x = 10'(px);
    y = 10'(py);
    frame_active = 1'b1;
    @(negedge clk);
    chk({tag, " lat1"}, 16'(pixel_valid), 16'h0);
    idle();
    @(negedge clk);
    chk({tag, " valid"}, 16'(pixel_valid), 16'h1);
    chk({tag, " rgb"}, 16'({r, g, b}), 16'(exp));
  endtask

  task automatic eofs(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      x = 10'd639;
      y = 10'd479;
      frame_active = 1'b1;
      @(negedge clk);
      idle();
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    mode = 2'd0;
    layer_en = 2'b00;
    #1;
    chk("reset rgb", 16'({r, g, b}), 16'h0);
    chk("reset valid", 16'(pixel_valid), 16'h0);
    chk("reset frame_cnt", 16'(frame_cnt), 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Checkerboard with sprites disabled from the next frame on.
    mode = 2'd2;
    layer_en = 2'b00;
    eofs(1);
    chk("chk frame_cnt", 16'(frame_cnt), 16'd1);
    probe("chk 32,0", 32, 0, C_WHITE);
    probe("chk 0,0", 0, 0, C_BLACK);
    probe("chk 0,32", 0, 32, C_WHITE);
    probe("chk 32,32", 32, 32, C_BLACK);

    // Inactive pixel gives no valid and black.
    @(negedge clk);
    idle();
    @(negedge clk);
    x = 10'd32;
    y = 10'd0;
    @(negedge clk);
    @(negedge clk);
    chk("inactive valid", 16'(pixel_valid), 16'h0);
    chk("inactive rgb", 16'({r, g, b}), 16'h0);

    // Bars, then a mid-frame change of mode and enables.
    mode = 2'd1;
    eofs(1);
    probe("bars 0", 0, 0, C_WHITE);
    probe("bars 128", 128, 0, C_YELLOW);
    probe("bars 512", 512, 100, C_MAGENTA);
    @(negedge clk);
    mode = 2'd3;
    layer_en = 2'b11;
    probe("midframe bars 128", 128, 0, C_YELLOW);
    probe("midframe en 1,1", 1, 1, C_WHITE);
    layer_en = 2'b00;
    eofs(1);
    chk("grad frame_cnt", 16'(frame_cnt), 16'd3);
    probe("grad 384,256", 384, 256, 6'b11_10_00);
    probe("grad 128,384", 128, 384, 6'b01_11_00);

    // Three frames of motion from reset.
    pulse_reset();
    chk("rst2 frame_cnt", 16'(frame_cnt), 16'd0);
    mode = 2'd0;
    layer_en = 2'b11;
    eofs(3);
    chk("move frame_cnt", 16'(frame_cnt), 16'd3);
    probe("l0 3,3", 3, 3, C_RED);
    probe("l0 2,3", 2, 3, C_BLACK);
    probe("l0 3,2", 3, 2, C_BLACK);
    probe("l0 34,34", 34, 34, C_RED);
    probe("l0 35,34", 35, 34, C_BLACK);
    probe("l1 70,54", 70, 54, C_GREEN);
    probe("l1 69,54", 69, 54, C_BLACK);
    probe("l1 70,53", 70, 53, C_BLACK);
    probe("l1 101,85", 101, 85, C_GREEN);
    probe("l1 102,85", 102, 85, C_BLACK);
    probe("l1 101,86", 101, 86, C_BLACK);

    // Priority: hold layer1 at (66,50) while layer0 walks into it.
    pulse_reset();
    layer_en = 2'b01;
    eofs(39);
    layer_en = 2'b11;
    eofs(1);
    probe("ovl 66,50", 66, 50, C_RED);
    probe("ovl 72,50", 72, 50, C_GREEN);
    probe("ovl 71,71", 71, 71, C_RED);
    probe("ovl 66,81", 66, 81, C_GREEN);
    layer_en = 2'b10;
    eofs(1);
    chk("ovl frame_cnt", 16'(frame_cnt), 16'h29);
    probe("dis 68,52", 68, 52, C_GREEN);
    probe("dis 66,50", 66, 50, C_BLACK);
    probe("dis 41,41", 41, 41, C_BLACK);

    // Right-edge bounce of layer1.
    pulse_reset();
    layer_en = 2'b11;
    eofs(273);
    chk("edge frame_cnt", 16'(frame_cnt), 16'd17);
    probe("edge 608,304", 608, 304, C_GREEN);
    probe("edge 607,304", 607, 304, C_BLACK);
    probe("edge 639,335", 639, 335, C_GREEN);
    probe("edge 639,336", 639, 336, C_BLACK);
    probe("edge 608,303", 608, 303, C_BLACK);
    eofs(1);
    chk("back frame_cnt", 16'(frame_cnt), 16'd18);
    probe("back 606,302", 606, 302, C_GREEN);
    probe("back 637,302", 637, 302, C_GREEN);
    probe("back 638,302", 638, 302, C_BLACK);

    // Mid-frame reset with a valid pixel in flight.
    @(negedge clk);
    x = 10'd606;
    y = 10'd302;
    frame_active = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid valid before", 16'(pixel_valid), 16'h1);
    chk("mid rgb before", 16'({r, g, b}), 16'(C_GREEN));
    rst = 1'b1;
    #1;
    chk("mid rst rgb", 16'({r, g, b}), 16'h0);
    chk("mid rst valid", 16'(pixel_valid), 16'h0);
    chk("mid rst frame_cnt", 16'(frame_cnt), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    x = 10'd0;
    y = 10'd0;
    @(negedge clk);
    chk("flush valid", 16'(pixel_valid), 16'h0);
    chk("flush rgb", 16'({r, g, b}), 16'h0);
    x = 10'd64;
    y = 10'd48;
    @(negedge clk);
    chk("reload l0 valid", 16'(pixel_valid), 16'h1);
    chk("reload l0 rgb", 16'({r, g, b}), 16'(C_RED));
    idle();
    @(negedge clk);
    chk("reload l1 rgb", 16'({r, g, b}), 16'(C_GREEN));
    chk("reload frame_cnt", 16'(frame_cnt), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
